// File: rtl/uart_fifo_sync_gen.sv
// Single-clock FIFO with configurable width/depth, runtime almost-full/empty
// thresholds, occupancy count, overflow/underflow pulses and a sticky error flag.
module uart_fifo_sync_gen #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             aresetn,
  input  logic             sclr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  input  logic [CW-1:0]    afull_level,
  input  logic [CW-1:0]    aempty_level,
  output logic             afull,
  output logic             aempty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  output logic             err_sticky
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             rd_accept;
  logic             wr_accept;

  // Explicit wrap so non-power-of-two depths use every location.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign afull  = (count >= afull_level);
  assign aempty = (count <= aempty_level);

  // A read frees a slot this edge, so a full FIFO may still take a write.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);

  always_comb begin
    count_nxt = count;
    if (wr_accept && !rd_accept)
      count_nxt = count + CW'(1);
    else if (!wr_accept && rd_accept)
      count_nxt = count - CW'(1);
  end

  // Storage stage: unreset RAM, written only on an accepted write.
  always_ff @(posedge clock) begin
    if (aresetn && !sclr && wr_accept)
      mem[wr_ptr] <= wr_data;
  end

  // Control/output stage: pointers, count, registered read data and flags.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      err_sticky <= 1'b0;
    end else if (sclr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (wr_accept)
        wr_ptr <= ptr_inc(wr_ptr);
      if (rd_accept) begin
        rd_ptr  <= ptr_inc(rd_ptr);
        rd_data <= mem[rd_ptr];
      end
      count      <= count_nxt;
      rd_valid   <= rd_accept;
      overflow   <= wr_en && !wr_accept;
      underflow  <= rd_en && !rd_accept;
      err_sticky <= err_sticky || (wr_en && !wr_accept) || (rd_en && !rd_accept);
    end
  end

endmodule

// File: tb/tb_uart_fifo_sync_gen.sv
// Directed bench: a 256-deep instance for basic flow and clear, a 5-deep
// instance for wrap, full/empty corner cases, thresholds and async reset.
module tb_uart_fifo_sync_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  // 256-deep instance
  logic       a_aresetn, a_sclr, a_wr_en, a_rd_en;
  logic [7:0] a_wr_data, a_rd_data;
  logic       a_rd_valid, a_full, a_empty, a_afull, a_aempty;
  logic [8:0] a_afull_level, a_aempty_level, a_count;
  logic       a_overflow, a_underflow, a_err;

  uart_fifo_sync_gen #(.WIDTH(8), .DEPTH(256)) dut_a (
    .clock(clock), .aresetn(a_aresetn), .sclr(a_sclr),
    .wr_en(a_wr_en), .wr_data(a_wr_data), .rd_en(a_rd_en),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full), .empty(a_empty),
    .afull_level(a_afull_level), .aempty_level(a_aempty_level),
    .afull(a_afull), .aempty(a_aempty), .count(a_count),
    .overflow(a_overflow), .underflow(a_underflow), .err_sticky(a_err)
  );

  // 5-deep instance
  logic       b_aresetn, b_sclr, b_wr_en, b_rd_en;
  logic [7:0] b_wr_data, b_rd_data;
  logic       b_rd_valid, b_full, b_empty, b_afull, b_aempty;
  logic [2:0] b_afull_level, b_aempty_level, b_count;
  logic       b_overflow, b_underflow, b_err;

  uart_fifo_sync_gen #(.WIDTH(8), .DEPTH(5)) dut_b (
    .clock(clock), .aresetn(b_aresetn), .sclr(b_sclr),
    .wr_en(b_wr_en), .wr_data(b_wr_data), .rd_en(b_rd_en),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full), .empty(b_empty),
    .afull_level(b_afull_level), .aempty_level(b_aempty_level),
    .afull(b_afull), .aempty(b_aempty), .count(b_count),
    .overflow(b_overflow), .underflow(b_underflow), .err_sticky(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    a_aresetn = 1'b0; a_sclr = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_data = '0;
    a_afull_level = 9'd200; a_aempty_level = 9'd0;
    b_aresetn = 1'b0; b_sclr = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_data = '0;
    b_afull_level = 3'd4; b_aempty_level = 3'd1;
    #2;
    check("a_rst_rd_data",  32'(a_rd_data), 32'h0);
    check("a_rst_rd_valid", 32'(a_rd_valid), 32'h0);
    check("a_rst_count",    32'(a_count), 32'h0);
    check("a_rst_empty",    32'(a_empty), 32'h1);
    check("a_rst_full",     32'(a_full), 32'h0);
    check("a_rst_afull",    32'(a_afull), 32'h0);
    check("a_rst_aempty",   32'(a_aempty), 32'h1);
    check("a_rst_ovf",      32'(a_overflow), 32'h0);
    check("a_rst_udf",      32'(a_underflow), 32'h0);
    check("a_rst_err",      32'(a_err), 32'h0);
    tick();
    a_aresetn = 1'b1; b_aresetn = 1'b1;

    // Basic write 5 / read 5 on the 256-deep FIFO
    a_wr_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      a_wr_data = 8'(i);
      tick();
    end
    a_wr_en = 1'b0;
    check("a_count5", 32'(a_count), 32'd5);
    check("a_empty0", 32'(a_empty), 32'h0);
    a_rd_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("a_rd_data", 32'(a_rd_data), 32'(i));
      check("a_rd_valid", 32'(a_rd_valid), 32'h1);
    end
    a_rd_en = 1'b0;
    tick();
    check("a_rd_valid_idle", 32'(a_rd_valid), 32'h0);
    check("a_empty_after", 32'(a_empty), 32'h1);
    check("a_udf_none", 32'(a_underflow), 32'h0);

    // Advance the 5-deep pointers to 3 so the fill below wraps
    b_wr_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      b_wr_data = 8'(i);
      tick();
    end
    b_wr_en = 1'b0;
    b_rd_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("b_pre_rd", 32'(b_rd_data), 32'(i));
    end
    b_rd_en = 1'b0;

    // Fill, overflow, drain across the wrap
    b_wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_wr_data = 8'(8'h10 + i);
      tick();
    end
    check("b_full", 32'(b_full), 32'h1);
    check("b_count_full", 32'(b_count), 32'd5);
    b_wr_data = 8'h99;
    tick();
    check("b_ovf_pulse", 32'(b_overflow), 32'h1);
    check("b_err_set", 32'(b_err), 32'h1);
    check("b_count_ovf", 32'(b_count), 32'd5);
    b_wr_en = 1'b0;
    tick();
    check("b_ovf_clear", 32'(b_overflow), 32'h0);
    check("b_err_hold", 32'(b_err), 32'h1);
    b_rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b_drain", 32'(b_rd_data), 32'(8'h10 + i));
    end
    b_rd_en = 1'b0;
    check("b_empty_drained", 32'(b_empty), 32'h1);

    // Full with simultaneous read and write
    b_wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_wr_data = 8'(8'h20 + i);
      tick();
    end
    b_rd_en = 1'b1;
    b_wr_data = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("b_rw_data", 32'(b_rd_data), (i < 5) ? 32'(8'h20 + i) : 32'hAA);
      check("b_rw_count", 32'(b_count), 32'd5);
      check("b_rw_ovf", 32'(b_overflow), 32'h0);
    end
    b_wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b_rw_drain", 32'(b_rd_data), 32'hAA);
    end
    b_rd_en = 1'b0;

    // Empty with simultaneous read and write: no fall-through
    b_wr_en = 1'b1; b_rd_en = 1'b1; b_wr_data = 8'h3C;
    tick();
    check("b_udf_pulse", 32'(b_underflow), 32'h1);
    check("b_udf_valid", 32'(b_rd_valid), 32'h0);
    check("b_udf_count", 32'(b_count), 32'd1);
    check("b_udf_hold", 32'(b_rd_data), 32'hAA);
    b_wr_en = 1'b0;
    tick();
    check("b_3c_data", 32'(b_rd_data), 32'h3C);
    check("b_3c_valid", 32'(b_rd_valid), 32'h1);
    check("b_udf_clear", 32'(b_underflow), 32'h0);
    b_rd_en = 1'b0;

    // Thresholds afull=4, aempty=1
    b_wr_en = 1'b1;
    b_wr_data = 8'h41; tick();
    b_wr_data = 8'h42; tick();
    check("b_aempty_c2", 32'(b_aempty), 32'h0);
    check("b_afull_c2", 32'(b_afull), 32'h0);
    b_wr_data = 8'h43; tick();
    check("b_afull_c3", 32'(b_afull), 32'h0);
    b_wr_data = 8'h44; tick();
    check("b_afull_c4", 32'(b_afull), 32'h1);
    check("b_count_c4", 32'(b_count), 32'd4);
    b_wr_en = 1'b0;
    b_rd_en = 1'b1;
    tick(); tick();
    check("b_aempty_r2", 32'(b_aempty), 32'h0);
    tick();
    check("b_aempty_r1", 32'(b_aempty), 32'h1);
    check("b_rd_43", 32'(b_rd_data), 32'h43);
    b_rd_en = 1'b0;

    // Async reset in the middle of a write burst
    b_wr_en = 1'b1;
    b_wr_data = 8'h55; tick();
    b_wr_data = 8'h66; tick();
    #3;
    b_aresetn = 1'b0;
    #1;
    check("b_ar_count", 32'(b_count), 32'h0);
    check("b_ar_empty", 32'(b_empty), 32'h1);
    check("b_ar_rd_data", 32'(b_rd_data), 32'h0);
    check("b_ar_err", 32'(b_err), 32'h0);
    check("b_ar_afull", 32'(b_afull), 32'h0);
    b_wr_en = 1'b0;
    tick();
    b_aresetn = 1'b1;
    b_wr_en = 1'b1; b_wr_data = 8'h77;
    tick();
    b_wr_en = 1'b0;
    check("b_ar_first_wr", 32'(b_count), 32'd1);

    // Synchronous clear with count 7 and err_sticky set
    a_rd_en = 1'b1;
    tick();
    a_rd_en = 1'b0;
    a_wr_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_wr_data = 8'(8'h80 + i);
      tick();
    end
    check("a_count7", 32'(a_count), 32'd7);
    check("a_err_set", 32'(a_err), 32'h1);
    a_sclr = 1'b1;
    tick();
    a_sclr = 1'b0; a_wr_en = 1'b0;
    check("a_sclr_count", 32'(a_count), 32'h0);
    check("a_sclr_empty", 32'(a_empty), 32'h1);
    check("a_sclr_err", 32'(a_err), 32'h0);
    check("a_sclr_rd_data", 32'(a_rd_data), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
